engine_sched: RTL and testbench
===============================

# engine_sched

Round-robin scheduler that shares one multi-cycle compute engine (a load/count style unit with a start/done handshake) among `NREQ` requesters. It sits between the requester ports of the test environment and the single engine instance. It arbitrates, forwards the winner's operand, waits for completion, and returns the result with a one-cycle acknowledge. Only one operation is in flight at a time.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 7, operand/result width in bits
- `TIMEOUT`, 64, engine-wait limit in cycles (used only with the configuration macro)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  NREQ  request per requester; held high until its `ack`
- `req_data`  in  NREQ*WIDTH  operand; slice i = bits [i*WIDTH +: WIDTH]
- `ack`  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
- `rsp_data`  out  WIDTH  result; valid in the `ack` cycle, held until the next response
- `err`  out  1  high with `ack` when the operation timed out
- `grant_id`  out  $clog2(NREQ)  index of current/last granted requester
- `busy`  out  1  high in every state except IDLE
- `eng_start`  out  1  one-cycle start pulse to the engine
- `eng_data`  out  WIDTH  operand to the engine; stable from ISSUE through WAIT
- `eng_done`  in  1  engine completion strobe
- `eng_result`  in  WIDTH  engine result, valid with `eng_done`

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req` bit is high, the winner is the first set bit at or after `ptr`, searching upward and wrapping modulo NREQ. Register `grant_id` and `eng_data` from that slice, then go to ISSUE. If no request is high, stay in IDLE.
- ISSUE: `eng_start`=1 for this cycle only, then go to WAIT.
- WAIT: `eng_done` is sampled only in this state. On `eng_done`, register `eng_result` into `rsp_data` and go to RESP.
- RESP: `ack[grant_id]`=1 for this cycle only. Set `ptr` to (`grant_id`+1) mod NREQ, then go to IDLE.
- `eng_done` in IDLE, ISSUE or RESP is ignored.
- A `req` dropped after grant does not abort the operation; the operation completes and `ack` still pulses.
- Requests that arrive while `busy` wait; arbitration happens only in IDLE.
- A requester with `req` still high after its `ack` is eligible again, but only after the other active requesters have been served.
- Reset values: state IDLE, `ptr`=0, `grant_id`=0, `ack`=0, `rsp_data`=0, `err`=0, `busy`=0, `eng_start`=0, `eng_data`=0.
- Reset asserted mid-operation returns the block to IDLE immediately. No `ack` is issued, and any later `eng_done` from the aborted operation is ignored.

## Timing
- All outputs are registered.
- A request is sampled high at edge N (state IDLE), giving ISSUE in cycle N+1 (`eng_start` high).
- The earliest `eng_done` is sampled in the first WAIT cycle (N+2), giving RESP and `ack` in cycle N+3.
- Minimum request-to-ack latency is 3 cycles plus the engine latency beyond 1 cycle.
- Maximum throughput is one operation per 4 cycles, because RESP always passes through IDLE.
- `err` is cleared in every cycle other than RESP.

## Configuration
- Macro `ENGINE_SCHED_TIMEOUT_EN`.
- Defined:
  - A wait counter clears on entry to WAIT and increments in every WAIT cycle without `eng_done`.
  - When the counter reaches TIMEOUT, go to RESP with `err`=1 and `rsp_data`=0.
  - `eng_done` and `TIMEOUT` in the same cycle: `eng_done` wins, `err`=0.
- Undefined:
  - No counter; WAIT lasts until `eng_done`.
  - `err` is tied to 0.

## Test plan
- Reset, then `req`=4'b0100, slice 2 = 7'h15, engine returns 7'h16 one cycle after `eng_start`:
  - `eng_data`=7'h15 and `eng_start` high in cycle 1.
  - `ack`=4'b0100 with `rsp_data`=7'h16 in cycle 3.
  - `grant_id`=2.
- `req`=4'b1111 held for 4 operations, starting from `ptr`=0: grant order is 0,1,2,3, then 0 again.
- `req`=4'b1001 with `ptr`=1: requester 3 is granted before 0 (wrap-around), then requester 0.
- `req` dropped in WAIT, engine done 5 cycles later: `ack` still pulses for that requester with the engine result.
- `reset` pulsed during WAIT, then a stray `eng_done`:
  - State IDLE, all outputs at reset values.
  - No `ack` follows.
- With `ENGINE_SCHED_TIMEOUT_EN` and `TIMEOUT`=8, engine never completes: `ack` with `err`=1 and `rsp_data`=0 after 8 WAIT cycles. Without the macro, `busy` stays high indefinitely.

Source files
------------

// File: rtl/engine_sched_if.sv
// rtl/engine_sched_if.sv - requester and engine signal bundle for engine_sched
interface engine_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 7
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      rsp_data;
    logic                  err;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic                  eng_start;
    logic [WIDTH-1:0]      eng_data;
    logic                  eng_done;
    logic [WIDTH-1:0]      eng_result;

    modport master (
        output req, req_data, eng_done, eng_result,
        input  ack, rsp_data, err, grant_id, busy, eng_start, eng_data
    );

    modport slave (
        input  req, req_data, eng_done, eng_result,
        output ack, rsp_data, err, grant_id, busy, eng_start, eng_data
    );
endinterface

// File: rtl/engine_sched.sv
// rtl/engine_sched.sv - round-robin scheduler sharing one start/done engine among NREQ requesters
// Optional engine-wait timeout enabled by defining ENGINE_SCHED_TIMEOUT_EN.
module engine_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    engine_sched_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   grant_id_q;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   idx;
    logic             found;
    logic [NREQ-1:0]  ack_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [WIDTH-1:0] eng_data_q;
    logic             busy_q;
    logic             eng_start_q;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("engine_sched: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    // First requesting slot at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef ENGINE_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    logic             err_q;

    // eng_done takes priority over an expiring counter.
    assign timed_out = (state_q == WAIT) && !bus.eng_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timed_out;
            if (state_q != WAIT) begin
                wait_cnt <= '0;
            end else if (!bus.eng_done) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (found) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.eng_done) begin
                    state_d = RESP;
                end
`ifdef ENGINE_SCHED_TIMEOUT_EN
                else if (timed_out) begin
                    state_d = RESP;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            ack_q       <= '0;
            rsp_data_q  <= '0;
            eng_data_q  <= '0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            eng_start_q <= (state_d == ISSUE);
            ack_q       <= '0;
            if (state_q == IDLE && found) begin
                grant_id_q <= win;
                eng_data_q <= bus.req_data[int'(win) * WIDTH +: WIDTH];
            end
            if (state_q == WAIT && bus.eng_done) begin
                rsp_data_q <= bus.eng_result;
            end
`ifdef ENGINE_SCHED_TIMEOUT_EN
            else if (timed_out) begin
                rsp_data_q <= '0;
            end
`endif
            if (state_d == RESP) begin
                ack_q[grant_id_q] <= 1'b1;
            end
            if (state_q == RESP) begin
                ptr_q <= (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
            end
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = busy_q;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_data  = eng_data_q;
endmodule

// File: tb/tb_engine_sched.sv
// tb/tb_engine_sched.sv - randomized and directed bench for engine_sched against a transaction-timeline model
module tb_engine_sched;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 7;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    engine_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    engine_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acks_seen = 0;
    int lat = 1;

    logic [NREQ-1:0]       req_v  = '0;
    logic [NREQ*WIDTH-1:0] data_v = '0;
    logic                  done_v = 1'b0;
    logic [WIDTH-1:0]      res_v  = '0;

    // Model: one operation described by the cycles at which it issues and acknowledges.
    bit               op_on = 1'b0;
    bit               op_err = 1'b0;
    int               op_grant = 0;
    int               issue_cyc = -1;
    int               ack_cyc = -1;
    int               m_ptr = 0;
    int               exp_grant = 0;
    logic [WIDTH-1:0] exp_data = '0;
    logic [WIDTH-1:0] exp_rsp = '0;
    int               grants[$];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        bit live;
        bit at_ack;
        live   = op_on && (ack_cyc < 0 || cyc <= ack_cyc);
        at_ack = op_on && (cyc == ack_cyc);
        check("busy", int'(bus.busy), live ? 1 : 0);
        check("eng_start", int'(bus.eng_start), (op_on && cyc == issue_cyc) ? 1 : 0);
        check("ack", int'(bus.ack), at_ack ? (1 << op_grant) : 0);
        check("err", int'(bus.err), (at_ack && op_err) ? 1 : 0);
        check("rsp_data", int'(bus.rsp_data), int'(exp_rsp));
        check("grant_id", int'(bus.grant_id), exp_grant);
        check("eng_data", int'(bus.eng_data), int'(exp_data));
    endtask

    // Applies what the DUT will sample at the end of cycle cyc.
    task automatic model_edge();
        bit idle;
        bit found;
        idle = !op_on || (ack_cyc >= 0 && cyc > ack_cyc);
        if (idle) begin
            if (req_v != '0) begin
                found = 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    int k;
                    k = (m_ptr + i) % NREQ;
                    if (!found && req_v[k]) begin
                        found = 1'b1;
                        op_grant = k;
                    end
                end
                op_on     = 1'b1;
                op_err    = 1'b0;
                issue_cyc = cyc + 1;
                ack_cyc   = -1;
                exp_grant = op_grant;
                exp_data  = data_v[op_grant * WIDTH +: WIDTH];
                grants.push_back(op_grant);
            end
        end else if (ack_cyc < 0 && cyc > issue_cyc) begin
            if (done_v) begin
                ack_cyc = cyc + 1;
                exp_rsp = res_v;
                m_ptr   = (op_grant + 1) % NREQ;
            end
`ifdef ENGINE_SCHED_TIMEOUT_EN
            else if (cyc - issue_cyc == TIMEOUT) begin
                ack_cyc = cyc + 1;
                exp_rsp = '0;
                op_err  = 1'b1;
                m_ptr   = (op_grant + 1) % NREQ;
            end
`endif
        end
    endtask

    task automatic step();
        bus.req        = req_v;
        bus.req_data   = data_v;
        bus.eng_done   = done_v;
        bus.eng_result = res_v;
        model_edge();
        @(negedge clk);
        cyc++;
        compare();
        if (bus.ack != '0) acks_seen++;
    endtask

    // Engine answers lat cycles into WAIT; stray strobes elsewhere must be ignored.
    task automatic auto_engine();
        res_v = WIDTH'($urandom);
        if (op_on && ack_cyc < 0 && cyc > issue_cyc) done_v = (cyc - issue_cyc >= lat);
        else done_v = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req_v  = '0;
        data_v = '0;
        done_v = 1'b0;
        res_v  = '0;
        bus.req = '0; bus.req_data = '0; bus.eng_done = 1'b0; bus.eng_result = '0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ack", int'(bus.ack), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_eng_start", int'(bus.eng_start), 0);
        check("rst_grant_id", int'(bus.grant_id), 0);
        check("rst_eng_data", int'(bus.eng_data), 0);
        check("rst_rsp_data", int'(bus.rsp_data), 0);
        @(negedge clk);
        @(negedge clk);
        op_on = 1'b0; op_err = 1'b0; issue_cyc = -1; ack_cyc = -1; m_ptr = 0;
        exp_grant = 0; exp_data = '0; exp_rsp = '0;
        grants.delete();
        reset = 1'b0;
        cyc   = 0;
        compare();
    endtask

    task automatic run_ops(int n, bit drop_on_ack);
        int budget;
        budget = 400;
        while (!(grants.size() >= n && op_on && ack_cyc >= 0 && cyc > ack_cyc)) begin
            if (budget == 0) begin
                check("run_ops_budget", 0, 1);
                return;
            end
            budget--;
            if (op_on && cyc == issue_cyc) lat = $urandom_range(1, 4);
            if (drop_on_ack && op_on && cyc == ack_cyc) req_v[op_grant] = 1'b0;
            data_v = (NREQ*WIDTH)'({$urandom, $urandom});
            auto_engine();
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        @(negedge clk);

        // Single request from slot 2, engine answers one cycle after start.
        do_reset();
        req_v  = 4'b0100;
        data_v = '0;
        data_v[2*WIDTH +: WIDTH] = 7'h15;
        step();
        check("t1_eng_start", int'(bus.eng_start), 1);
        check("t1_eng_data", int'(bus.eng_data), 'h15);
        check("t1_grant_id", int'(bus.grant_id), 2);
        step();
        done_v = 1'b1;
        res_v  = 7'h16;
        step();
        check("t1_ack", int'(bus.ack), 'b0100);
        check("t1_rsp_data", int'(bus.rsp_data), 'h16);
        req_v  = '0;
        done_v = 1'b0;
        step();

        // All four requesting continuously: strict rotation from slot 0.
        do_reset();
        req_v = 4'b1111;
        run_ops(5, 1'b0);
        if (grants.size() >= 5) begin
            check("t2_g0", grants[0], 0);
            check("t2_g1", grants[1], 1);
            check("t2_g2", grants[2], 2);
            check("t2_g3", grants[3], 3);
            check("t2_g4", grants[4], 0);
        end else begin
            check("t2_grant_count", grants.size(), 5);
        end

        // Pointer at 1 with slots 0 and 3 requesting: 3 wins, then 0.
        do_reset();
        req_v = 4'b0001;
        run_ops(1, 1'b1);
        req_v = 4'b1001;
        run_ops(3, 1'b1);
        if (grants.size() >= 3) begin
            check("t3_g1", grants[1], 3);
            check("t3_g2", grants[2], 0);
        end else begin
            check("t3_grant_count", grants.size(), 3);
        end

        // Request withdrawn during WAIT; the operation still completes.
        do_reset();
        req_v  = 4'b0010;
        data_v = '0;
        data_v[1*WIDTH +: WIDTH] = 7'h2B;
        done_v = 1'b0;
        step();
        check("t4_eng_data", int'(bus.eng_data), 'h2B);
        step();
        req_v = '0;
        for (int t = 0; t < 5; t++) step();
        done_v = 1'b1;
        res_v  = 7'h5A;
        step();
        check("t4_ack", int'(bus.ack), 'b0010);
        check("t4_rsp_data", int'(bus.rsp_data), 'h5A);
        done_v = 1'b0;
        step();

        // Reset pulsed in WAIT, followed by a stray engine completion.
        do_reset();
        req_v  = 4'b1000;
        data_v = (NREQ*WIDTH)'({$urandom, $urandom});
        step();
        step();
        do_reset();
        acks_seen = 0;
        done_v = 1'b1;
        res_v  = 7'h33;
        step();
        done_v = 1'b0;
        for (int t = 0; t < 4; t++) step();
        check("t5_no_ack", acks_seen, 0);

        // Engine never completes.
        do_reset();
        acks_seen = 0;
        req_v  = 4'b0001;
        data_v = (NREQ*WIDTH)'({$urandom, $urandom});
        done_v = 1'b0;
`ifdef ENGINE_SCHED_TIMEOUT_EN
        for (int t = 0; t < 10; t++) step();
        check("t6_ack", int'(bus.ack), 1);
        check("t6_err", int'(bus.err), 1);
        check("t6_rsp_data", int'(bus.rsp_data), 0);
        req_v = '0;
        step();
`else
        for (int t = 0; t < 100; t++) step();
        check("t6_busy_held", int'(bus.busy), 1);
        check("t6_no_ack", acks_seen, 0);
`endif

        // Random traffic against the model.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            if (op_on && cyc == issue_cyc) lat = ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(1, 5);
            for (int i = 0; i < NREQ; i++) begin
                if (req_v[i]) begin
                    if (op_on && cyc == ack_cyc && op_grant == i && $urandom_range(0, 1) == 0)
                        req_v[i] = 1'b0;
                    else if (op_on && ack_cyc < 0 && cyc > issue_cyc && op_grant == i && $urandom_range(0, 31) == 0)
                        req_v[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_v[i] = 1'b1;
                end
            end
            data_v = (NREQ*WIDTH)'({$urandom, $urandom});
            auto_engine();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
